ov7670_capture: RTL
===================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320, meaning pixels written per line.
REQ-002 SHALL have parameter V_LINES, default 240, meaning lines written per frame.
REQ-003 SHALL define localparam DEPTH = H_PIXELS*V_LINES and AW = $clog2(DEPTH).
REQ-004 i_Clk  input  1  camera PCLK; the only clock; all logic on its rising edge.
REQ-005 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-006 i_Capture_En  input  1  level; high = capture frames continuously.
REQ-007 i_VSync  input  1  camera VSYNC, synchronous to i_Clk; high = vertical blanking.
REQ-008 i_HRef  input  1  camera HREF, synchronous to i_Clk; high = active bytes on i_Data.
REQ-009 i_Data  input  8  camera byte, RGB444 xR GB order.
REQ-010 o_Wr_Addr  output  AW  frame-buffer write address.
REQ-011 o_Wr_DV  output  1  one-cycle write strobe.
REQ-012 o_Wr_Data  output  12  pixel {R[3:0],G[3:0],B[3:0]}.
REQ-013 o_Frame_Done  output  1  one-cycle pulse at end of each captured frame.
REQ-014 o_Frame_Err  output  1  geometry error for the last completed frame; held until the next frame starts.
REQ-015 o_Busy  output  1  high in any state other than S_IDLE.

Function
REQ-016 FSM SHALL have states S_IDLE, S_ARM, S_SYNC and S_FRAME.
REQ-017 S_IDLE->S_ARM when i_Capture_En=1; S_ARM->S_SYNC when i_VSync=1; S_ARM and S_SYNC return to S_IDLE when i_Capture_En=0.
REQ-018 S_SYNC->S_FRAME on a cycle with i_VSync=0 (frame start); frame start clears the column, line, address, byte-phase and error registers and sets o_Frame_Err=0.
REQ-019 In S_FRAME, a cycle with i_VSync=1 SHALL end the frame: pulse o_Frame_Done for 1 cycle, then go to S_SYNC if i_Capture_En=1, else to S_IDLE; i_Capture_En is not checked mid-frame.
REQ-020 Byte phase SHALL reset to 0 on each HREF rising edge and toggle on every cycle with i_HRef=1; phase 0 latches i_Data[3:0] as R; phase 1 forms the pixel {R,i_Data[7:4],i_Data[3:0]}.
REQ-021 Pixel formed at cycle N SHALL appear on o_Wr_Data/o_Wr_Addr with o_Wr_DV=1 at cycle N+1 (registered); o_Wr_DV=0 otherwise.
REQ-022 Address SHALL equal line*H_PIXELS+column, maintained by a line-base register plus column counter; no multiplier.
REQ-023 HREF falling edge SHALL advance the line counter and reset the column counter.
REQ-024 Pixels with column>=H_PIXELS or line>=V_LINES SHALL be dropped (no o_Wr_DV) and set the error flag; the address never exceeds DEPTH-1.
REQ-025 HREF falling with phase=1 (odd byte count) SHALL discard the half pixel and set the error flag.
REQ-026 A line that ends with column!=H_PIXELS, or a frame that ends with line count!=V_LINES, SHALL set the error flag.
REQ-027 The error flag SHALL be copied to o_Frame_Err in the same cycle o_Frame_Done pulses.
REQ-028 HREF activity outside S_FRAME SHALL be ignored.

Reset
REQ-029 Assertion of i_Rst_L=0 SHALL immediately force S_IDLE, all counters 0, o_Wr_Addr=0, o_Wr_Data=0, o_Wr_DV=0, o_Frame_Done=0, o_Frame_Err=0 and o_Busy=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no o_Frame_Done; capture resumes only via S_ARM (a full VSYNC cycle).

Structure
REQ-031 A shared package SHALL hold the state encoding and the RGB444 field widths (4/4/4, pixel width 12).
REQ-032 One sub-module, ov7670_pixel_pack (byte phase and pixel assembly), is natural; the counters and FSM SHALL remain in ov7670_capture.

Verification (H_PIXELS=4, V_LINES=3)
REQ-033 Test 1: enable, VSync 1->0, 3 lines of 8 bytes -> 12 writes at addr 0..11, pixel = {byte0[3:0],byte1} per pair, VSync rise -> Done pulse, Err=0.
REQ-034 Test 2: byte pair 0x0A,0x5C -> o_Wr_Data=12'hA5C exactly 1 cycle after byte 0x5C.
REQ-035 Test 3: line of 10 bytes -> 4 writes only, addresses not past 4*line+3, Err=1 at Done.
REQ-036 Test 4: line of 7 bytes -> 3 writes, Err=1; enable in S_FRAME with VSync already low -> no writes until the next full VSync cycle.
REQ-037 Test 5: i_Rst_L=0 mid-line -> all outputs 0 immediately, no Done; i_Capture_En=0 mid-frame -> frame completes, Done pulses, FSM goes to S_IDLE.

Source files
------------

// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 RGB444 capture path: FSM encoding,
// pixel field widths and the byte-pair to pixel packing rule.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_SYNC  = 2'd2,
    S_FRAME = 2'd3
  } state_t;

  localparam int BYTE_W = 8;
  localparam int R_W    = 4;
  localparam int G_W    = 4;
  localparam int B_W    = 4;
  localparam int PIX_W  = R_W + G_W + B_W;

  // Second byte of an RGB444 pair carries G in the high nibble, B in the low.
  function automatic logic [PIX_W-1:0] pack_rgb(input logic [R_W-1:0]    red,
                                                input logic [BYTE_W-1:0] gb);
    return {red, gb[BYTE_W-1 -: G_W], gb[B_W-1:0]};
  endfunction

endpackage

// File: rtl/ov7670_pixel_pack.sv
// Byte-phase tracking and pixel assembly for the xR / GB byte stream.
// Reports completed pixels combinationally; the capture top registers them.
module ov7670_pixel_pack
  import ov7670_capture_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_En,
  input  logic              i_Clr,
  input  logic              i_HRef,
  input  logic [BYTE_W-1:0] i_Data,
  output logic              o_Pix_Valid,
  output logic [PIX_W-1:0]  o_Pix,
  output logic              o_Line_End,
  output logic              o_Half_Drop
);

  logic           href_q;
  logic           phase_q;
  logic [R_W-1:0] red_q;
  logic           href_rise;
  logic           cur_phase;

  // The first byte after an HREF rise is always phase 0, whatever was left over.
  assign href_rise   = i_HRef & ~href_q;
  assign cur_phase   = href_rise ? 1'b0 : phase_q;
  assign o_Pix_Valid = i_En & i_HRef & cur_phase;
  assign o_Pix       = pack_rgb(red_q, i_Data);
  assign o_Line_End  = i_En & ~i_HRef & href_q;
  assign o_Half_Drop = o_Line_End & phase_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      red_q   <= '0;
    end else begin
      href_q <= i_HRef;
      if (i_Clr) begin
        phase_q <= 1'b0;
        red_q   <= '0;
      end else if (i_En && i_HRef) begin
        phase_q <= ~cur_phase;
        if (!cur_phase) begin
          red_q <= i_Data[R_W-1:0];
        end
      end else if (o_Line_End) begin
        phase_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: VSYNC-framed FSM, line/column addressing into a
// linear frame buffer, and per-frame geometry error reporting.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter  int H_PIXELS = 320,
  parameter  int V_LINES  = 240,
  localparam int DEPTH    = H_PIXELS * V_LINES,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Capture_En,
  input  logic              i_VSync,
  input  logic              i_HRef,
  input  logic [BYTE_W-1:0] i_Data,
  output logic [AW-1:0]     o_Wr_Addr,
  output logic              o_Wr_DV,
  output logic [PIX_W-1:0]  o_Wr_Data,
  output logic              o_Frame_Done,
  output logic              o_Frame_Err,
  output logic              o_Busy
);

  // Counters run one past the legal maximum so over-long lines and frames
  // remain distinguishable from exact ones.
  localparam int CW = $clog2(H_PIXELS + 2);
  localparam int LW = $clog2(V_LINES + 2);

  localparam logic [CW-1:0] COL_FULL  = CW'(H_PIXELS);
  localparam logic [CW-1:0] COL_SAT   = CW'(H_PIXELS + 1);
  localparam logic [LW-1:0] LINE_FULL = LW'(V_LINES);
  localparam logic [LW-1:0] LINE_SAT  = LW'(V_LINES + 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(H_PIXELS);

  state_t           state_q;
  logic [CW-1:0]    col_q;
  logic [LW-1:0]    line_q;
  logic [AW-1:0]    base_q;
  logic             err_q;
  logic [AW-1:0]    wr_addr_q;
  logic             wr_dv_q;
  logic [PIX_W-1:0] wr_data_q;
  logic             done_q;
  logic             frame_err_q;
  logic             busy_q;

  logic             dp_en;
  logic             frame_start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix;
  logic             line_end;
  logic             half_drop;
  logic             pix_ok;
  logic             pix_drop;
  logic             line_bad;
  logic             err_d;

  // Bytes are only consumed inside a frame and outside vertical blanking.
  assign dp_en       = (state_q == S_FRAME) & ~i_VSync;
  assign frame_start = (state_q == S_SYNC) & i_Capture_En & ~i_VSync;

  ov7670_pixel_pack u_pack (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_En        (dp_en),
    .i_Clr       (frame_start),
    .i_HRef      (i_HRef),
    .i_Data      (i_Data),
    .o_Pix_Valid (pix_valid),
    .o_Pix       (pix),
    .o_Line_End  (line_end),
    .o_Half_Drop (half_drop)
  );

  assign pix_ok   = pix_valid & (col_q < COL_FULL) & (line_q < LINE_FULL);
  assign pix_drop = pix_valid & ~pix_ok;
  assign line_bad = line_end & (half_drop | (col_q != COL_FULL));
  assign err_d    = err_q | pix_drop | line_bad;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      line_q      <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_dv_q     <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_dv_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= err_d;

      if (pix_ok) begin
        wr_dv_q   <= 1'b1;
        wr_addr_q <= base_q + AW'(col_q);
        wr_data_q <= pix;
      end

      if (pix_valid && (col_q != COL_SAT)) begin
        col_q <= col_q + 1'b1;
      end

      // Line base stops at the last legal row so addresses stay below DEPTH.
      if (line_end) begin
        col_q <= '0;
        if (line_q != LINE_SAT) begin
          line_q <= line_q + 1'b1;
        end
        if (line_q < LINE_LAST) begin
          base_q <= base_q + ROW_STEP;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (i_Capture_En) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          if (!i_Capture_En) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (i_VSync) begin
            state_q <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (!i_Capture_En) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!i_VSync) begin
            state_q     <= S_FRAME;
            col_q       <= '0;
            line_q      <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        S_FRAME: begin
          if (i_VSync) begin
            done_q      <= 1'b1;
            frame_err_q <= err_q | (line_q != LINE_FULL);
            state_q     <= i_Capture_En ? S_SYNC : S_IDLE;
            busy_q      <= i_Capture_En;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_DV      = wr_dv_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Busy       = busy_q;

endmodule
